// File: rtl/la_iopwrseq.sv
// IO ring supply sequencer: brings N supply segments up one at a time in order, waits for each power-ok,
// releases ring isolation once all are up, and tears the segments down in reverse order.
//
// state | meaning
// OFF   | all segments off, ring isolated, waiting for en
// RAMP  | seg_en[idx] just enabled, counting down the settle delay
// CHECK | waiting up to TOUT cycles for synchronized pok[idx]
// ON    | every segment up, isolation released, ready asserted
// DOWN  | ring isolated, segments switched off from idx down to 0
// FAULT | all segments off, fault latched until en drops
module la_iopwrseq #(
    parameter     PROP  = "DEFAULT",
    parameter int N     = 4,
    parameter int DLYW  = 8,
    parameter int TOUT  = 255,
    parameter int RINGW = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic [DLYW-1:0]  dly,
    input  logic [N-1:0]     pok,
    output logic [N-1:0]     seg_en,
    output logic             ready,
    output logic             fault,
    output logic [RINGW-1:0] ioring
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(TOUT + 1);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if (N < 1 || TOUT < 1 || RINGW < 2 || PROP == "") begin : g_param_check
        $error("la_iopwrseq: illegal parameter value");
    end

    typedef enum logic [2:0] {OFF, RAMP, CHECK, ON, DOWN, FAULT} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [DLYW-1:0] cnt;
    logic [TW-1:0]   tcnt;
    logic            iso;
    logic [N-1:0]    pok_m;
    logic [N-1:0]    pok_s;

    // pok comes straight from the analog supply cells and is asynchronous to clk
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pok_m <= '0;
            pok_s <= '0;
        end else begin
            pok_m <= pok;
            pok_s <= pok_m;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= OFF;
            idx    <= '0;
            cnt    <= '0;
            tcnt   <= '0;
            seg_en <= '0;
            ready  <= 1'b0;
            fault  <= 1'b0;
            iso    <= 1'b1;
        end else begin
            case (state)
                OFF: begin
                    if (en) begin
                        state     <= RAMP;
                        idx       <= '0;
                        seg_en[0] <= 1'b1;
                        cnt       <= dly;
                    end
                end
                RAMP: begin
                    if (!en) begin
                        state <= DOWN;
                        cnt   <= dly;
                    end else if (cnt == '0) begin
                        state <= CHECK;
                        tcnt  <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (!en) begin
                        state <= DOWN;
                        cnt   <= dly;
                    end else if (pok_s[idx]) begin
                        if (idx == LAST) begin
                            state <= ON;
                            ready <= 1'b1;
                            iso   <= 1'b0;
                        end else begin
                            state              <= RAMP;
                            idx                <= idx + 1'b1;
                            seg_en[idx + 1'b1] <= 1'b1;
                            cnt                <= dly;
                        end
                    end else if (tcnt == TW'(TOUT)) begin
                        state  <= FAULT;
                        seg_en <= '0;
                        fault  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ON: begin
                    if (!(&pok_s)) begin
                        state  <= FAULT;
                        seg_en <= '0;
                        ready  <= 1'b0;
                        iso    <= 1'b1;
                        fault  <= 1'b1;
                    end else if (!en) begin
                        // isolate the ring before the first segment is switched off
                        state <= DOWN;
                        idx   <= LAST;
                        cnt   <= dly;
                        ready <= 1'b0;
                        iso   <= 1'b1;
                    end
                end
                DOWN: begin
                    if (cnt == '0) begin
                        seg_en[idx] <= 1'b0;
                        if (idx == '0) begin
                            state <= OFF;
                        end else begin
                            idx <= idx - 1'b1;
                            cnt <= dly;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FAULT: begin
                    if (!en) begin
                        state <= OFF;
                        fault <= 1'b0;
                    end
                end
                default: state <= OFF;
            endcase
        end
    end

    always_comb begin
        ioring    = '0;
        ioring[0] = iso;
        ioring[1] = ready;
    end

endmodule

// File: tb/tb_la_iopwrseq.sv
// Bench for la_iopwrseq: a pok model that follows seg_en one cycle late, and a scoreboard of
// expected seg_en steps (value plus cycle spacing) checked whenever seg_en changes.
module tb_la_iopwrseq;

    localparam int N     = 4;
    localparam int DLYW  = 8;
    localparam int TOUT  = 10;
    localparam int RINGW = 8;

    logic             clk = 1'b0;
    logic             nreset;
    logic             en;
    logic [DLYW-1:0]  dly;
    logic [N-1:0]     pok;
    logic [N-1:0]     seg_en;
    logic             ready;
    logic             fault;
    logic [RINGW-1:0] ioring;

    logic [N-1:0] pok_d = '0;
    logic [N-1:0] kill;
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0;

    typedef struct {
        logic [N-1:0] seg;
        int           gap;
    } exp_t;
    exp_t sb_q[$];

    la_iopwrseq #(.PROP("DEFAULT"), .N(N), .DLYW(DLYW), .TOUT(TOUT), .RINGW(RINGW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .en     (en),
        .dly    (dly),
        .pok    (pok),
        .seg_en (seg_en),
        .ready  (ready),
        .fault  (fault),
        .ioring (ioring)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // supply cell model: pok follows seg_en one cycle later, kill forces selected bits low
    always @(posedge clk) pok_d <= seg_en;
    assign pok = pok_d & ~kill;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // gap 0 means the spacing from the previous step is not checked
    task automatic push_exp(input logic [N-1:0] s, input int g);
        exp_t e;
        e.seg = s;
        e.gap = g;
        sb_q.push_back(e);
    endtask

    function automatic logic is_therm(input logic [N-1:0] s);
        logic [N:0] t;
        t = {1'b0, s} + 1'b1;
        return (({1'b0, s} & t) == '0);
    endfunction

    task automatic wait_seg(input logic [N-1:0] v, input string tag);
        int n = 0;
        while (seg_en !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (seg_en !== v) chk(tag, seg_en, v);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) chk(tag, ready, 1);
    endtask

    task automatic wait_fault(input string tag);
        int n = 0;
        while (fault !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (fault !== 1'b1) chk(tag, fault, 1);
    endtask

    logic [N-1:0] prev_seg = '0;
    int           last_chg = 0;
    always @(negedge clk) begin
        exp_t e;
        if (seg_en !== prev_seg) begin
            if (sb_q.size() == 0) begin
                chk("seg_extra", seg_en, prev_seg);
            end else begin
                e = sb_q.pop_front();
                chk("seg_seq", seg_en, e.seg);
                if (e.gap != 0) chk("seg_gap", cyc - last_chg, e.gap);
            end
            chk("seg_therm", is_therm(seg_en), 1);
            chk("ring_hi", ioring[RINGW-1:2], 0);
            last_chg = cyc;
            prev_seg = seg_en;
        end
        if (ready === 1'b1) chk("rdy_inv", {ioring[1:0], seg_en}, {2'b10, 4'hF});
        if (fault === 1'b1) chk("flt_inv", seg_en, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0;
        en     = 1'b0;
        dly    = 8'd3;
        kill   = '0;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg_en, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ring", ioring, 8'h01);
        nreset = 1'b1;
        @(negedge clk);

        // ordered power-up, dly=3: each step is dly+1 RAMP cycles plus one CHECK cycle
        push_exp(4'b0001, 0); push_exp(4'b0011, 5); push_exp(4'b0111, 5); push_exp(4'b1111, 5);
        en = 1'b1;
        wait_ready("up_ready_tmo");
        chk("up_ring", ioring, 8'h02);
        chk("up_seg", seg_en, 4'hF);
        repeat (3) @(negedge clk);
        chk("on_hold", ready, 1);

        // reverse teardown: isolation first, then one segment every dly+1 cycles
        push_exp(4'b0111, 0); push_exp(4'b0011, 4); push_exp(4'b0001, 4); push_exp(4'b0000, 4);
        en = 1'b0;
        @(negedge clk);
        chk("dn_ring", ioring, 8'h01);
        chk("dn_ready", ready, 0);
        chk("dn_seg_hold", seg_en, 4'hF);
        wait_seg(4'b0000, "dn_off_tmo");
        repeat (4) @(negedge clk);
        chk("off_seg", seg_en, 0);
        chk("off_ring", ioring, 8'h01);

        // pok[2] never rises: CHECK of idx 2 starts dly+1 cycles after 0111, times out TOUT+1 cycles later
        kill = 4'b0100;
        push_exp(4'b0001, 0); push_exp(4'b0011, 5); push_exp(4'b0111, 5); push_exp(4'b0000, 15);
        en = 1'b1;
        wait_seg(4'b0111, "flt_ramp_tmo");
        t0 = cyc;
        wait_fault("flt_tmo");
        chk("flt_lat", cyc - t0, 15);
        chk("flt_seg", seg_en, 0);
        chk("flt_ring", ioring, 8'h01);
        repeat (3) @(negedge clk);
        chk("flt_hold", fault, 1);
        en = 1'b0;
        @(negedge clk);
        chk("flt_clr", fault, 0);
        kill = '0;
        repeat (3) @(negedge clk);

        // pok[1] drop while ON: two synchronizer cycles plus one decision cycle
        push_exp(4'b0001, 0); push_exp(4'b0011, 5); push_exp(4'b0111, 5); push_exp(4'b1111, 5);
        en = 1'b1;
        wait_ready("pd_ready_tmo");
        push_exp(4'b0000, 0);
        kill = 4'b0010;
        t0 = cyc;
        wait_fault("pd_tmo");
        chk("pd_lat", cyc - t0, 3);
        chk("pd_seg", seg_en, 0);
        chk("pd_ring", ioring, 8'h01);
        repeat (2) @(negedge clk);
        kill = '0;
        @(negedge clk);
        chk("pd_hold", fault, 1);
        en = 1'b0;
        @(negedge clk);
        chk("pd_clr", fault, 0);
        repeat (3) @(negedge clk);

        // en drops in RAMP of idx 2, comes back mid-teardown: teardown completes, restart next cycle
        push_exp(4'b0001, 0); push_exp(4'b0011, 5); push_exp(4'b0111, 5);
        en = 1'b1;
        wait_seg(4'b0111, "ab_ramp_tmo");
        en = 1'b0;
        push_exp(4'b0011, 0); push_exp(4'b0001, 4); push_exp(4'b0000, 4);
        push_exp(4'b0001, 1); push_exp(4'b0011, 5); push_exp(4'b0111, 5); push_exp(4'b1111, 5);
        wait_seg(4'b0011, "ab_dn_tmo");
        en = 1'b1;
        chk("ab_iso", ioring, 8'h01);
        wait_ready("ab_ready_tmo");
        chk("ab_ring", ioring, 8'h02);

        // dly=0: one cycle per teardown step; power-up steps limited by the 3-cycle pok path
        dly = 8'd0;
        push_exp(4'b0111, 0); push_exp(4'b0011, 1); push_exp(4'b0001, 1); push_exp(4'b0000, 1);
        en = 1'b0;
        wait_seg(4'b0000, "z_dn_tmo");
        repeat (5) @(negedge clk);
        push_exp(4'b0001, 0); push_exp(4'b0011, 4); push_exp(4'b0111, 4); push_exp(4'b1111, 4);
        en = 1'b1;
        wait_ready("z_ready_tmo");
        chk("z_ring", ioring, 8'h02);

        // nreset pulse in RAMP of idx 1: outputs return to reset values without waiting for clk
        push_exp(4'b0111, 0); push_exp(4'b0011, 1); push_exp(4'b0001, 1); push_exp(4'b0000, 1);
        en = 1'b0;
        wait_seg(4'b0000, "r_dn_tmo");
        repeat (5) @(negedge clk);
        dly = 8'd3;
        push_exp(4'b0001, 0); push_exp(4'b0011, 5);
        en = 1'b1;
        wait_seg(4'b0011, "r_ramp_tmo");
        push_exp(4'b0000, 0);
        #1 nreset = 1'b0;
        #1;
        chk("r_seg", seg_en, 0);
        chk("r_ring", ioring, 8'h01);
        chk("r_ready", ready, 0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        push_exp(4'b0001, 0); push_exp(4'b0011, 5); push_exp(4'b0111, 5); push_exp(4'b1111, 5);
        wait_ready("r_ready_tmo");

        push_exp(4'b0111, 0); push_exp(4'b0011, 4); push_exp(4'b0001, 4); push_exp(4'b0000, 4);
        en = 1'b0;
        wait_seg(4'b0000, "fin_dn_tmo");
        repeat (5) @(negedge clk);
        chk("fin_seg", seg_en, 0);
        chk("fin_fault", fault, 0);
        chk("fin_ring", ioring, 8'h01);
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
